// File: rtl/mem_fifo_ctrl.sv
// mem_fifo_ctrl: FIFO controller in front of an external 2^DEPTH-word memory.
// The memory has a 1-cycle registered read. A small output stage made of the
// pend and ov flags keeps full throughput across that read latency.
//
// Ports
//   CLK, RESETn            : clock (rising edge), async active-low reset
//   FLUSH                  : synchronous clear of all stored content
//   S_VALID/S_READY/S_DATA : write-side handshake
//   M_VALID/M_READY/M_DATA : read-side handshake (M_DATA is registered)
//   MEM_WEN/WADDR/DIN      : memory write port
//   MEM_REN/RADDR/DOUT     : memory read port (DOUT valid the cycle after REN,
//                            and held while REN is low)
//   FULL, EMPTY            : status flags
//   LEVEL                  : words held in total (memory + pend + ov), only
//                            present when MEM_FIFO_CTRL_LEVEL_EN is defined
module mem_fifo_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RESETn,
    input  logic             FLUSH,
    input  logic             S_VALID,
    output logic             S_READY,
    input  logic [WIDTH-1:0] S_DATA,
    output logic             M_VALID,
    input  logic             M_READY,
    output logic [WIDTH-1:0] M_DATA,
    output logic             MEM_WEN,
    output logic [DEPTH-1:0] MEM_WADDR,
    output logic [WIDTH-1:0] MEM_DIN,
    output logic             MEM_REN,
    output logic [DEPTH-1:0] MEM_RADDR,
    input  logic [WIDTH-1:0] MEM_DOUT,
    output logic             FULL,
    output logic             EMPTY
`ifdef MEM_FIFO_CTRL_LEVEL_EN
    ,
    output logic [DEPTH+1:0] LEVEL
`endif
);

    // Output-stage state, encoded as {ov, pend}
    localparam logic [1:0] ST_EMPTY     = 2'b00;
    localparam logic [1:0] ST_FETCHED   = 2'b01;
    localparam logic [1:0] ST_HOLD      = 2'b10;
    localparam logic [1:0] ST_HOLD_BOTH = 2'b11;

    logic [DEPTH:0] wptr, rptr;
    logic [1:0]     ostate, ostate_nxt;
    logic           ov, pend;
    logic           mem_empty, wr_hs, rd_hs, load;

    assign ov   = ostate[1];
    assign pend = ostate[0];

    // The extra pointer MSB tells a full memory apart from an empty one
    assign mem_empty = (wptr == rptr);
    assign FULL      = (wptr[DEPTH-1:0] == rptr[DEPTH-1:0]) && (wptr[DEPTH] != rptr[DEPTH]);

    assign S_READY = !FULL && !FLUSH;
    assign wr_hs   = S_VALID && S_READY;

    assign MEM_WEN   = wr_hs;
    assign MEM_WADDR = wptr[DEPTH-1:0];
    assign MEM_DIN   = S_DATA;

    assign M_VALID = ov;
    assign rd_hs   = ov && M_READY;

    // The fetched word moves into M_DATA when that register is free or
    // is being drained in this cycle.
    assign load = pend && (!ov || rd_hs);

    // Fetch again only when the memory-output slot is free or is being
    // emptied by a load. An unconsumed MEM_DOUT is therefore never overwritten.
    assign MEM_REN   = !mem_empty && (!pend || load) && !FLUSH;
    assign MEM_RADDR = rptr[DEPTH-1:0];

    assign EMPTY = mem_empty && !pend && !ov;

`ifdef MEM_FIFO_CTRL_LEVEL_EN
    logic [DEPTH:0] used;
    assign used  = wptr - rptr;
    assign LEVEL = (DEPTH+2)'(used) + (DEPTH+2)'(pend) + (DEPTH+2)'(ov);
`endif

    always_comb begin
        ostate_nxt = ostate;
        case (ostate)
            ST_EMPTY:     ostate_nxt = MEM_REN ? ST_FETCHED : ST_EMPTY;
            // ov is clear, so a load always happens here
            ST_FETCHED:   ostate_nxt = MEM_REN ? ST_HOLD_BOTH : ST_HOLD;
            ST_HOLD:      begin
                if (rd_hs) ostate_nxt = MEM_REN ? ST_FETCHED : ST_EMPTY;
                else       ostate_nxt = MEM_REN ? ST_HOLD_BOTH : ST_HOLD;
            end
            // Both slots are busy. Move only when the consumer takes the word.
            ST_HOLD_BOTH: begin
                if (load)  ostate_nxt = MEM_REN ? ST_HOLD_BOTH : ST_HOLD;
                else       ostate_nxt = ST_HOLD_BOTH;
            end
            default:      ostate_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            wptr   <= '0;
            rptr   <= '0;
            ostate <= ST_EMPTY;
            M_DATA <= '0;
        end else if (FLUSH) begin
            // Any handshake in this cycle is dropped
            wptr   <= '0;
            rptr   <= '0;
            ostate <= ST_EMPTY;
        end else begin
            if (wr_hs)   wptr <= wptr + (DEPTH+1)'(1);
            if (MEM_REN) rptr <= rptr + (DEPTH+1)'(1);
            ostate <= ostate_nxt;
            if (load)    M_DATA <= MEM_DOUT;
        end
    end

endmodule
